// File: rtl/alu_issue_stage.sv
// Two-stage issue/capture pipeline around the 32-bit ALU: stage 1 holds the
// operands that drive the ALU, stage 2 holds the result and flags.
// Optional sticky overflow/carry accumulation is built when STICKY_FLAGS_EN is defined.

module alu_issue_alu #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_s,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_cout
);
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [4:0]       w_shamt;
  logic             w_lt;

  assign w_add   = {1'b0, i_a} + {1'b0, i_b};
  // Subtract as a + ~b + 1 so the carry out means "no borrow".
  assign w_sub   = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shamt = i_b[4:0];
  assign w_lt    = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_out  = '0;
    o_ovf  = 1'b0;
    o_cout = 1'b0;
    case (i_s)
      3'd0: begin
        o_out  = w_add[WIDTH-1:0];
        o_cout = w_add[WIDTH];
        o_ovf  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
      end
      3'd1: begin
        o_out  = w_sub[WIDTH-1:0];
        o_cout = w_sub[WIDTH];
        o_ovf  = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);
      end
      3'd2:    o_out = i_a ^ i_b;
      3'd3:    o_out = {{(WIDTH-1){1'b0}}, w_lt};
      3'd4:    o_out = i_a << w_shamt;
      3'd5:    o_out = i_a >> w_shamt;
      3'd6:    o_out = $unsigned($signed(i_a) >>> w_shamt);
      default: o_out = '0;
    endcase
  end

  assign o_zero = (o_out == '0);
endmodule

module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_cout,
  output logic             out_illegal
`ifdef STICKY_FLAGS_EN
  ,
  input  logic             clear_flags,
  output logic             sticky_ovf,
  output logic             sticky_cout
`endif
);
  localparam int STAGES = 2;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             cout;
    logic             illegal;
  } rsp_t;

  logic [STAGES:1] r_vld_pipe;
  req_t            r_req;
  rsp_t            r_rsp;
  rsp_t            w_rsp;
  logic            w_s1_free;
  logic            w_s2_free;
  logic [WIDTH-1:0] w_alu_out;
  logic            w_alu_zero;
  logic            w_alu_ovf;
  logic            w_alu_cout;

  assign w_s2_free = !r_vld_pipe[2] || out_ready;
  assign w_s1_free = !r_vld_pipe[1] || w_s2_free;
  assign in_ready  = w_s1_free;

  // Operand register feeds the ALU directly, so ALU inputs only move on a stage-1 load.
  alu_issue_alu #(.WIDTH(WIDTH)) u_alu (
    .i_s    (r_req.op),
    .i_a    (r_req.a),
    .i_b    (r_req.b),
    .o_out  (w_alu_out),
    .o_zero (w_alu_zero),
    .o_ovf  (w_alu_ovf),
    .o_cout (w_alu_cout)
  );

  always_comb begin
    w_rsp = '{result: w_alu_out, zero: w_alu_zero, ovf: w_alu_ovf,
              cout: w_alu_cout, illegal: 1'b0};
    if (r_req.op == OP_ILLEGAL)
      w_rsp = '{result: '0, zero: 1'b1, ovf: 1'b0, cout: 1'b0, illegal: 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[1] <= 1'b0;
      r_req         <= '0;
    end else if (w_s1_free) begin
      r_vld_pipe[1] <= in_valid;
      if (in_valid)
        r_req <= '{op: in_op, a: in_a, b: in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[2] <= 1'b0;
      r_rsp         <= '0;
    end else if (w_s2_free) begin
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (r_vld_pipe[1])
        r_rsp <= w_rsp;
    end
  end

  assign out_valid   = r_vld_pipe[2];
  assign out_result  = r_rsp.result;
  assign out_zero    = r_rsp.zero;
  assign out_ovf     = r_rsp.ovf;
  assign out_cout    = r_rsp.cout;
  assign out_illegal = r_rsp.illegal;

`ifdef STICKY_FLAGS_EN
  logic r_sticky_ovf;
  logic r_sticky_cout;

  // Accumulate only when a legal result actually leaves; clear wins over set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_ovf  <= 1'b0;
      r_sticky_cout <= 1'b0;
    end else if (clear_flags) begin
      r_sticky_ovf  <= 1'b0;
      r_sticky_cout <= 1'b0;
    end else if (r_vld_pipe[2] && out_ready && !r_rsp.illegal) begin
      r_sticky_ovf  <= r_sticky_ovf  | r_rsp.ovf;
      r_sticky_cout <= r_sticky_cout | r_rsp.cout;
    end
  end

  assign sticky_ovf  = r_sticky_ovf;
  assign sticky_cout = r_sticky_cout;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: table of hand-computed vectors checked through an
// in-order scoreboard, plus backpressure, illegal-op, latency and reset sequences.

module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero, out_ovf, out_cout, out_illegal;
`ifdef STICKY_FLAGS_EN
  logic        clear_flags = 1'b0;
  logic        sticky_ovf, sticky_cout;
`endif

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_cout(out_cout), .out_illegal(out_illegal)
`ifdef STICKY_FLAGS_EN
    , .clear_flags(clear_flags), .sticky_ovf(sticky_ovf), .sticky_cout(sticky_cout)
`endif
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        z, o, c, ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z, o, c, ill;
  } exp_t;

  vec_t tv[15];
  exp_t sbq[$];
  exp_t cur_exp;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_op = v.op;
    in_a = v.a;
    in_b = v.b;
    cur_exp = '{res: v.res, z: v.z, o: v.o, c: v.c, ill: v.ill};
  endtask

  // Evaluate handshakes just before the edge, then advance one cycle.
  task automatic step(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result actual=%h required=none", out_result);
      end else begin
        e = sbq.pop_front();
        chk("result", out_result, e.res);
        chk("zero", {31'b0, out_zero}, {31'b0, e.z});
        chk("ovf", {31'b0, out_ovf}, {31'b0, e.o});
        chk("cout", {31'b0, out_cout}, {31'b0, e.c});
        chk("illegal", {31'b0, out_illegal}, {31'b0, e.ill});
      end
    end
    if (acc) sbq.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && (sbq.size() != 0 || out_valid); k++) step(acc);
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    bit   acc;
    vec_t r3[3];
    logic [31:0] held;

    //       op    a             b             res           z     o     c     ill
    tv[0]  = '{3'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{3'd1, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{3'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{3'd3, 32'h3,        32'h7,        32'h1,        1'b0, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{3'd3, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{3'd3, 32'h7,        32'h3,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{3'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{3'd1, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{3'd1, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[9]  = '{3'd4, 32'h1,        32'd31,       32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[10] = '{3'd5, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[11] = '{3'd6, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[12] = '{3'd4, 32'h1,        32'd33,       32'h2,        1'b0, 1'b0, 1'b0, 1'b0};
    tv[13] = '{3'd7, 32'h1,        32'h1,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
    tv[14] = '{3'd0, 32'h1,        32'h1,        32'h2,        1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_illegal", {31'b0, out_illegal}, 32'h0);
`ifdef STICKY_FLAGS_EN
    chk("rst_sticky", {30'b0, sticky_ovf, sticky_cout}, 32'h0);
`endif
    rst_n = 1'b1;

    // Latency: accepted at edge N, valid after edge N+1
    out_ready = 1'b1;
    drive(tv[0]);
    step(acc);
    chk("lat_accept", {31'b0, acc}, 32'h1);
    in_valid = 1'b0;
    chk("lat_not_yet", {31'b0, out_valid}, 32'h0);
    step(acc);
    chk("lat_valid", {31'b0, out_valid}, 32'h1);
    drain();

    // Back-to-back table stream at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(tv[i]);
      step(acc);
      chk($sformatf("b2b_accept_%0d", i), {31'b0, acc}, 32'h1);
    end
    drain();

    // Backpressure: three offered, two taken, output held, then all three in order
    r3[0] = tv[2]; r3[1] = tv[3]; r3[2] = tv[8];
    out_ready = 1'b0;
    drive(r3[0]); step(acc); chk("bp_acc0", {31'b0, acc}, 32'h1);
    drive(r3[1]); step(acc); chk("bp_acc1", {31'b0, acc}, 32'h1);
    drive(r3[2]);
    held = out_result;
    chk("bp_held_first", held, 32'hF0F00F0F);
    for (int k = 0; k < 3; k++) begin
      step(acc);
      chk("bp_stall_ready", {31'b0, acc}, 32'h0);
      chk("bp_hold_result", out_result, 32'hF0F00F0F);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    step(acc);
    chk("bp_resume_accept", {31'b0, acc}, 32'h1);
    drain();

`ifdef STICKY_FLAGS_EN
    clear_flags = 1'b1; in_valid = 1'b0; step(acc); clear_flags = 1'b0;
    out_ready = 1'b1;
    drive(tv[0]); step(acc);
    drive(tv[14]); step(acc);
    drain();
    chk("sticky_ovf_set", {31'b0, sticky_ovf}, 32'h1);
    chk("sticky_cout_clr", {31'b0, sticky_cout}, 32'h0);
    clear_flags = 1'b1; step(acc); clear_flags = 1'b0;
    chk("sticky_cleared", {30'b0, sticky_ovf, sticky_cout}, 32'h0);
`endif

    // Reset mid-stream drops in-flight work
    out_ready = 1'b0;
    drive(tv[1]); step(acc);
    drive(tv[6]); step(acc);
    in_valid = 1'b0;
    chk("mid_full_valid", {31'b0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'h1);
`ifdef STICKY_FLAGS_EN
    chk("mid_rst_sticky", {30'b0, sticky_ovf, sticky_cout}, 32'h0);
`endif
    sbq.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(acc);
      chk("post_rst_no_stale", {31'b0, out_valid}, 32'h0);
    end
    drive(tv[10]); step(acc);
    chk("post_rst_accept", {31'b0, acc}, 32'h1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Two-stage operand-issue and result-capture pipeline wrapped around the 32-bit ALU datapath. It accepts operation requests on a valid/ready handshake, holds operands stable in a stage-1 register that drives the ALU's S, A and B inputs, and captures out, Zero, Overflow and Cout into a stage-2 result register. It presents the result downstream on a second valid/ready handshake. The ALU is instantiated inside this block, so this block is the only path between the register file/decoder and the ALU.

## Interface
- WIDTH, 32, datapath width; fixed at 32 to match the ALU.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts the request this cycle.
- in_op  input  3  ALU select S.
  - 0 add, 1 sub, 2 xor, 3 slt, 4–6 shift.
  - 7 illegal.
- in_a, in_b  input  32  operands.
- out_valid  output  1  result present.
- out_ready  input  1  downstream consumes the result this cycle.
- out_result  output  32  registered ALU out.
- out_zero, out_ovf, out_cout  output  1 each  registered ALU flags.
- out_illegal  output  1  the request used op 7.
- clear_flags  input  1  clears the sticky flags; only present with STICKY_FLAGS_EN.
- sticky_ovf, sticky_cout  output  1 each  accumulated flags; only present with STICKY_FLAGS_EN.

## Operation
- Stage 1 holds s1_valid, s1_op, s1_a and s1_b. These registers drive the ALU directly, so the ALU inputs change only on a stage-1 load.
- Stage 2 holds s2_valid, the result, the flags and the illegal bit, all captured from the ALU outputs and from s1_op.
- s2_free = !s2_valid || out_ready.
- s1_free = !s1_valid || s2_free.
- in_ready = s1_free. It is combinational and depends on out_ready.
- Accept occurs when in_valid && in_ready. On accept, stage 1 loads op, a and b and sets s1_valid=1. If stage 1 is free and there is no input, s1_valid clears.
- Stage-2 load occurs when s1_valid && s2_free: the stage captures the ALU outputs and sets s2_valid=1. If s2_free holds and s1_valid=0, s2_valid clears.
- Illegal op 7:
  - The request is accepted normally.
  - Stage 2 stores out_result=0, out_zero=1, out_ovf=0, out_cout=0 and out_illegal=1.
  - The ALU output is ignored.
- Stage registers never change while their valid bit is set and the downstream stage is stalled. Outputs stay stable under backpressure.
- Asserting in_valid while in_ready=0 has no effect. The requester must hold the request.

## Timing
- Reset, asynchronous on rst_n=0, forces:
  - s1_valid=0 and s2_valid=0;
  - all data and flag registers to 0;
  - out_valid=0, out_illegal=0, sticky_ovf=0, sticky_cout=0.
- in_ready=1 during and after reset, because stage 1 is empty.
- Latency: a request accepted at edge N gives out_valid=1 after edge N+1.
- Throughput is one result per cycle while out_ready=1.
- Full pipe with out_ready=0: both valid bits are set, in_ready=0, and the outputs hold.
- When out_ready rises on a full pipe, the result is consumed, stage 1 advances and a new request is accepted, all at the same edge.
- Reset mid-operation drops all in-flight requests with no partial output. The first acceptance is possible at the first edge after rst_n deasserts.

## Configuration
- STICKY_FLAGS_EN defined:
  - sticky_ovf |= out_ovf and sticky_cout |= out_cout, applied on each stage-2 consume (out_valid && out_ready) of a legal op.
  - clear_flags=1 zeroes both flags at the edge and takes priority over a same-cycle set.
  - Reset clears both flags.
- STICKY_FLAGS_EN undefined: clear_flags, sticky_ovf, sticky_cout and their registers are absent. All other behaviour is identical.

## Test plan
- Reset, then op=0, a=0x7FFFFFFF, b=1, out_ready=1 → two cycles later out_result=0x80000000, out_ovf=1, out_zero=0, out_cout=0.
- op=1, a=5, b=5 → out_result=0, out_zero=1, out_cout=1.
- Back-to-back ops xor(0xFFFF0000, 0x0F0F0F0F), then slt(3, 7), with out_ready=1 → consecutive-cycle results 0xF0F00F0F then 1; in_ready stays 1 throughout.
- Backpressure: out_ready=0 with 3 requests offered → 2 accepted, then in_ready=0 and out_result held. Raising out_ready delivers all 3 in order with none lost or duplicated.
- op=7, a=1, b=1 → out_illegal=1, out_result=0, out_zero=1; the next legal op reports out_illegal=0.
- With STICKY_FLAGS_EN: an overflowing add, then a clean add → sticky_ovf stays 1. clear_flags pulse → 0. rst_n low mid-stream → out_valid=0 immediately and no stale result after release.
